// File: rtl/app_host.sv
// Host-side initiator/checker for the app demo responder: issues escape+command
// byte streams, moves LFSR payload bytes and checks the returned data and CRC32.
module app_host #(
  parameter int TIMEOUT = 'd65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [23:0] arg_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [23:0] err_cnt_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // HDR0/1 | send escape 00, then command byte
  // ARG0-2 | send argument bytes, LSB first
  // PAY_TX | send N+1 LFSR bytes (OUT_TEST);  PAY_RX | receive and check them (IN_TEST)
  // CRC0-3 | receive and check the four CRC32 bytes
  // DONE   | one-cycle done_o pulse, result valid
  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_ARG0, S_ARG1, S_ARG2, S_PAY_TX, S_PAY_RX,
    S_CRC0, S_CRC1, S_CRC2, S_CRC3, S_DONE
  } state_t;

  localparam logic [1:0] OP_SEED = 2'd0;
  localparam logic [1:0] OP_OUT  = 2'd1;
  localparam logic [1:0] OP_IN   = 2'd2;
  localparam logic [1:0] OP_WAIT = 2'd3;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic logic [31:0] crc32_step(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 8; i++) begin
      if (v[31] ^ d[i]) v = {v[30:0], 1'b0} ^ 32'h04C11DB7;
      else              v = {v[30:0], 1'b0};
    end
    return v;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  state_t        r_state;
  logic [1:0]    r_op;
  logic [23:0]   r_arg;
  logic [23:0]   r_lfsr;
  logic [31:0]   r_crc;
  logic [23:0]   r_cnt;
  logic [23:0]   r_err_cnt;
  logic [TW-1:0] r_tmr;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_rx_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;

  logic          w_tx_fire;
  logic          w_rx_fire;
  logic [31:0]   w_crc_nxt;
  logic [23:0]   w_lfsr_nxt;
  logic [31:0]   w_crc_inv;
  logic [7:0]    w_crc_exp;
  logic [7:0]    w_rx_exp;
  logic          w_rx_bad;
  logic          w_err_sat;
  logic          w_timeout;
  logic [7:0]    w_cmd;

  assign w_tx_fire  = r_tx_valid & tx_ready_i;
  assign w_rx_fire  = r_rx_ready & rx_valid_i;
  assign w_crc_nxt  = crc32_step(r_lfsr[7:0], r_crc);
  assign w_lfsr_nxt = {r_lfsr[22:0], ~^(r_lfsr & 24'hE10000)};
  assign w_crc_inv  = ~r_crc;
  assign w_err_sat  = &r_err_cnt;
  assign w_rx_exp   = (r_state == S_PAY_RX) ? r_lfsr[7:0] : w_crc_exp;
  assign w_rx_bad   = w_rx_fire & (rx_data_i != w_rx_exp);
  assign w_timeout  = (TIMEOUT != 0) && r_rx_ready && !rx_valid_i && (r_tmr == '0);

  always_comb begin
    w_crc_exp = 8'h00;
    case (r_state)
      S_CRC0:  w_crc_exp = rev8(w_crc_inv[31:24]);
      S_CRC1:  w_crc_exp = rev8(w_crc_inv[23:16]);
      S_CRC2:  w_crc_exp = rev8(w_crc_inv[15:8]);
      S_CRC3:  w_crc_exp = rev8(w_crc_inv[7:0]);
      default: w_crc_exp = 8'h00;
    endcase
  end

  always_comb begin
    w_cmd = 8'h04;
    case (r_op)
      OP_SEED: w_cmd = 8'h04;
      OP_OUT:  w_cmd = 8'h02;
      OP_IN:   w_cmd = 8'h01;
      default: w_cmd = 8'h03;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_op       <= OP_SEED;
      r_arg      <= '0;
      r_lfsr     <= '0;
      r_crc      <= '0;
      r_cnt      <= '0;
      r_err_cnt  <= '0;
      r_tmr      <= TLOAD;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Idle timer restarts on every cycle a byte is offered or outside RX states
      if (!r_rx_ready || rx_valid_i) r_tmr <= TLOAD;
      else if (r_tmr != '0)          r_tmr <= r_tmr - 1'b1;
      if (w_rx_bad && !w_err_sat) r_err_cnt <= r_err_cnt + 24'd1;

      case (r_state)
        S_IDLE: if (start_i) begin
          r_op       <= op_i;
          r_arg      <= arg_i;
          r_err_cnt  <= '0;
          r_pass     <= 1'b0;
          r_busy     <= 1'b1;
          r_tx_valid <= 1'b1;
          r_tx_data  <= 8'h00;
          r_state    <= S_HDR0;
        end
        S_HDR0: if (w_tx_fire) begin
          r_tx_data <= w_cmd;
          r_state   <= S_HDR1;
        end
        S_HDR1: if (w_tx_fire) begin
          r_tx_data <= r_arg[7:0];
          r_state   <= S_ARG0;
        end
        S_ARG0: if (w_tx_fire) begin
          if (r_op == OP_WAIT) begin
            r_tx_valid <= 1'b0;
            r_pass     <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_tx_data <= r_arg[15:8];
            r_state   <= S_ARG1;
          end
        end
        S_ARG1: if (w_tx_fire) begin
          r_tx_data <= r_arg[23:16];
          r_state   <= S_ARG2;
        end
        S_ARG2: if (w_tx_fire) begin
          r_crc <= 32'hFFFFFFFF;
          r_cnt <= r_arg;
          if (r_op == OP_SEED) begin
            r_lfsr     <= r_arg;
            r_tx_valid <= 1'b0;
            r_pass     <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_op == OP_OUT) begin
            r_tx_data <= r_lfsr[7:0];
            r_state   <= S_PAY_TX;
          end else begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= S_PAY_RX;
          end
        end
        S_PAY_TX: if (w_tx_fire) begin
          r_crc  <= w_crc_nxt;
          r_lfsr <= w_lfsr_nxt;
          r_cnt  <= r_cnt - 24'd1;
          if (r_cnt == '0) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= S_CRC0;
          end else begin
            r_tx_data <= w_lfsr_nxt[7:0];
          end
        end
        S_PAY_RX: if (w_rx_fire) begin
          r_crc  <= w_crc_nxt;
          r_lfsr <= w_lfsr_nxt;
          r_cnt  <= r_cnt - 24'd1;
          if (r_cnt == '0) r_state <= S_CRC0;
        end
        S_CRC0: if (w_rx_fire) r_state <= S_CRC1;
        S_CRC1: if (w_rx_fire) r_state <= S_CRC2;
        S_CRC2: if (w_rx_fire) r_state <= S_CRC3;
        S_CRC3: if (w_rx_fire) begin
          r_rx_ready <= 1'b0;
          r_pass     <= (r_err_cnt == '0) && !w_rx_bad;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_rx_ready <= 1'b0;
        r_pass     <= 1'b0;
        r_done     <= 1'b1;
        r_state    <= S_DONE;
      end
    end
  end

  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign rx_ready_o = r_rx_ready;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign pass_o     = r_pass;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: doc/app_host.md
Name: app_host

Overview:
- Command initiator and checker for the `app` demo responder. It generates the escape/command byte streams that `app` accepts on its OUT channel and consumes the bytes `app` returns on its IN channel.
- It checks the returned data and CRC32 words against a locally computed copy, then reports pass/fail.
- It sits in place of the USB_CDC host side, both in the on-FPGA self-test build and on the test bench.

Parameters:
- TIMEOUT, 'd65535: clk_i cycles to wait for an rx byte before aborting with failure; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  launch operation; sampled only in IDLE
- op_i  in  2  operation: 0 = LFSR_SEED, 1 = OUT_TEST, 2 = IN_TEST, 3 = WAIT_SET
- arg_i  in  24  seed (LFSR_SEED), byte count N (OUT/IN_TEST; N+1 bytes move), wait value in arg_i[7:0] (WAIT_SET)
- tx_data_o  out  8  byte to app out_data_i
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  app out_ready_o
- rx_data_i  in  8  byte from app in_data_o
- rx_valid_i  in  1  app in_valid_o
- rx_ready_o  out  1  to app in_ready_i
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse at end of operation
- pass_o  out  1  result of last operation; held until next start
- err_cnt_o  out  24  mismatching rx bytes in last operation; saturates at FFFFFF

Behaviour:
- Interface fixed: one clock clk_i; reset rst_i synchronous, active-high.
- Reset values: tx_valid_o=0, tx_data_o=00, rx_ready_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, lfsr=000000, state IDLE.
- Reset asserted mid-operation returns the block to IDLE with reset values in the same edge. No partial-byte cleanup.
- Handshakes:
  - A byte transfers on a cycle with valid&ready high.
  - tx_valid_o and tx_data_o stay stable until accepted.
  - rx_ready_o is high only in RX states.
  - Each state issues at most one tx and one rx byte per cycle.
- start_i in IDLE:
  - Latch op_i and arg_i; clear err_cnt_o and pass_o.
  - Set busy_o; go to HDR0.
  - start_i outside IDLE is ignored.
- HDR0: send 00 (escape).
- HDR1: send command byte: LFSR_SEED 04, OUT_TEST 02, IN_TEST 01, WAIT_SET 03.
- ARG0/ARG1/ARG2: send arg[7:0], arg[15:8], arg[23:16], LSB first.
  - WAIT_SET sends only ARG0, then finishes with pass.
  - LFSR_SEED also loads the local lfsr with arg on ARG2 acceptance, then finishes with pass.
- CRC init: before the payload of OUT/IN_TEST, crc = FFFFFFFF and byte counter = N.
- Payload step for OUT_TEST (PAY_TX) and IN_TEST (PAY_RX):
  - Data byte is lfsr[7:0].
  - On each transfer: crc = crc32_step(byte, crc); lfsr = {lfsr[22:0], XNOR-reduce(lfsr & E10000)}.
  - Byte counter decrements; after the transfer at counter 0, go to CRC0.
- crc32_step: poly 04C11DB7, register shifts MSB-first, data bits fed LSB-first (bit0 first).
- PAY_RX (IN_TEST) only: each rx byte is compared with local lfsr[7:0]; a mismatch increments err_cnt_o.
- CRC0..CRC3: receive 4 bytes and compare against rev8(~crc[31:24]), rev8(~crc[23:16]), rev8(~crc[15:8]), rev8(~crc[7:0]) in that order. Each mismatch increments err_cnt_o.
- DONE (one cycle):
  - done_o=1; busy_o=0 next cycle.
  - pass_o = (err_cnt_o==0) and no timeout.
  - Return to IDLE.
- Timeout: in any RX state, if rx_valid_i stays low for TIMEOUT consecutive cycles, go to DONE with pass_o=0. err_cnt_o is unchanged.
- Counter widths:
  - Byte counter is 24 bit. N=FFFFFF moves 2^24 bytes with no wrap error.
  - err_cnt_o saturates at FFFFFF.
- Data value 00 inside the payload is sent raw, with no escaping.

Test Plan:
- LFSR_SEED arg=123456 -> tx bytes 00 04 56 34 12; done_o pulse; pass_o=1; local lfsr=123456.
- OUT_TEST after seed 000000, N=0, responder returns 8D EF 02 D2 -> tx 00 02 00 00 00 00; pass_o=1; err_cnt_o=0.
- Same as previous, but responder returns 8D EF 02 D3 -> pass_o=0; err_cnt_o=1.
- IN_TEST N=3 against a real `app` instance seeded 0ABCDE, with tx_ready_i and rx_valid_i randomly throttled -> 4 payload bytes match local lfsr; CRC matches; pass_o=1; tx_data_o never changes while tx_valid_o=1 and tx_ready_i=0.
- IN_TEST with TIMEOUT=16 and a silent responder -> done_o 16 cycles after entering the first RX state; pass_o=0.
- rst_i pulsed during PAY_TX, and start_i pulsed while busy -> reset clears to IDLE with all outputs at reset values on the next cycle; the mid-operation start is ignored; a new start then runs normally.
